can_bit_destuffer: RTL and testbench

- Consumes the sample strobes and synchronized bus level from the CAN bit-sync stage.
- Resolves one logical bit per CAN bit period: single sample, or 3-sample majority when multi-sampling.
- Tracks bus-idle and start-of-frame (SOF), removes stuff bits inside frames and flags stuff errors.
- Feeds destuffed bits with a valid strobe to the downstream CAN frame decoder.

---
 rtl/can_bit_destuffer_if.sv | 39 +++
 rtl/can_bit_destuffer.sv | 217 +++++++++++++++++++++
 tb/tb_can_bit_destuffer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_bit_destuffer_if.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer_if
// Bundles the bit-sync / frame-decoder side signals of the CAN bit destuffer.
//   master : bit-sync stage + frame decoder (drives strobes, observes bits)
//   slave  : can_bit_destuffer
// Signals:
//   syncIn, oneShotSample, syncCANClk, multiSelect  - from bit-sync stage
//   stuffEnable, frameEnd                           - from frame decoder
//   bitOut, bitValid, stuffDrop, stuffErr, busIdle,
//   sampleMiss, stuffCount, errCount                - from destuffer
// ---------------------------------------------------------------------------
interface can_bit_destuffer_if;
   logic        syncIn;
   logic        oneShotSample;
   logic        syncCANClk;
   logic        multiSelect;
   logic        stuffEnable;
   logic        frameEnd;
   logic        bitOut;
   logic        bitValid;
   logic        stuffDrop;
   logic        stuffErr;
   logic        busIdle;
   logic        sampleMiss;
   logic [15:0] stuffCount;
   logic [15:0] errCount;

   modport master (
      output syncIn, oneShotSample, syncCANClk, multiSelect, stuffEnable, frameEnd,
      input  bitOut, bitValid, stuffDrop, stuffErr, busIdle, sampleMiss,
             stuffCount, errCount
   );

   modport slave (
      input  syncIn, oneShotSample, syncCANClk, multiSelect, stuffEnable, frameEnd,
      output bitOut, bitValid, stuffDrop, stuffErr, busIdle, sampleMiss,
             stuffCount, errCount
   );
endinterface

// File: rtl/can_bit_destuffer.sv
// ---------------------------------------------------------------------------
// can_bit_destuffer
// Resolves one CAN bit per bit period (single sample or 3-sample majority),
// tracks bus idle / SOF, removes stuff bits and flags stuff errors.
// Ports:
//   clk    - system clock
//   resetN - asynchronous active-low reset
//   bus    - can_bit_destuffer_if.slave (strobes in, destuffed bits out)
// Optional: define DESTUFF_STATS_EN to build the 16-bit saturating
//   stuffCount / errCount statistics counters; otherwise both read 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset / frame end: counting recessive bits to idle
// BUS_IDLE | bus idle seen, waiting for a dominant SOF bit
// ACTIVE   | inside a frame, emitting (and destuffing) bits
// ERROR    | stuff error seen, counting recessive bits to idle
// ---------------------------------------------------------------------------
module can_bit_destuffer #(
   parameter int IDLE_BITS = 11,
   parameter int STUFF_LEN = 5
) (
   input  logic               clk,
   input  logic               resetN,
   can_bit_destuffer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUS_IDLE = 2'd1,
      S_ACTIVE   = 2'd2,
      S_ERROR    = 2'd3
   } state_t;

   localparam logic [3:0] IDLE_MAX = 4'(IDLE_BITS);
   localparam logic [2:0] RUN_MAX  = 3'(STUFF_LEN);

   state_t     r_state;
   logic       r_can_clk_q;
   logic [1:0] r_samp_cnt;
   logic [1:0] r_slot;
   logic       r_mode_multi;
   logic [3:0] r_idle_cnt;
   logic [2:0] r_run_cnt;
   logic       r_run_pol;
   logic       r_bit_out;
   logic       r_bit_valid;
   logic       r_stuff_drop;
   logic       r_stuff_err;
   logic       r_bus_idle;
   logic       r_sample_miss;

   logic       w_bit_start;
   logic [1:0] w_cnt_eff;
   logic       w_mode_eff;
   logic       w_maj;
   logic       w_res_vld;
   logic       w_res_bit;
   logic       w_miss;

   assign w_bit_start = bus.syncCANClk & ~r_can_clk_q;

   // A strobe landing on the bit-start clk belongs to the new bit.
   assign w_cnt_eff  = w_bit_start ? 2'd0 : r_samp_cnt;
   assign w_mode_eff = w_bit_start ? bus.multiSelect : r_mode_multi;

   assign w_maj = (r_slot[0] & r_slot[1]) | (r_slot[0] & bus.syncIn) |
                  (r_slot[1] & bus.syncIn);

   assign w_res_vld = bus.oneShotSample &
                      ((!w_mode_eff && (w_cnt_eff == 2'd0)) ||
                       ( w_mode_eff && (w_cnt_eff == 2'd2)));
   assign w_res_bit = w_mode_eff ? w_maj : bus.syncIn;

   assign w_miss = w_bit_start & r_mode_multi &
                   ((r_samp_cnt == 2'd1) || (r_samp_cnt == 2'd2));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_can_clk_q  <= 1'b0;
         r_samp_cnt   <= 2'd0;
         r_slot       <= 2'b00;
         r_mode_multi <= 1'b0;
      end else begin
         r_can_clk_q <= bus.syncCANClk;
         if (w_bit_start) begin
            r_mode_multi <= bus.multiSelect;
         end
         if (bus.oneShotSample) begin
            if (w_cnt_eff != 2'd3) begin
               r_samp_cnt <= w_cnt_eff + 2'd1;
            end
            if (w_cnt_eff < 2'd2) begin
               r_slot[w_cnt_eff[0]] <= bus.syncIn;
            end
         end else if (w_bit_start) begin
            r_samp_cnt <= 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state       <= S_IDLE;
         r_idle_cnt    <= 4'd0;
         r_run_cnt     <= 3'd0;
         r_run_pol     <= 1'b1;
         r_bit_out     <= 1'b1;
         r_bit_valid   <= 1'b0;
         r_stuff_drop  <= 1'b0;
         r_stuff_err   <= 1'b0;
         r_bus_idle    <= 1'b0;
         r_sample_miss <= 1'b0;
      end else begin
         r_bit_valid   <= 1'b0;
         r_stuff_drop  <= 1'b0;
         r_stuff_err   <= 1'b0;
         r_sample_miss <= w_miss;
         case (r_state)
            S_IDLE, S_ERROR: begin
               r_bus_idle <= 1'b0;
               if (w_res_vld) begin
                  if (w_res_bit) begin
                     if (r_idle_cnt >= IDLE_MAX - 4'd1) begin
                        r_idle_cnt <= IDLE_MAX;
                        r_state    <= S_BUS_IDLE;
                        r_bus_idle <= 1'b1;
                     end else begin
                        r_idle_cnt <= r_idle_cnt + 4'd1;
                     end
                  end else begin
                     r_idle_cnt <= 4'd0;
                  end
               end
            end
            S_BUS_IDLE: begin
               r_bus_idle <= 1'b1;
               if (w_res_vld && !w_res_bit) begin
                  r_bit_out   <= 1'b0;
                  r_bit_valid <= 1'b1;
                  r_run_pol   <= 1'b0;
                  r_run_cnt   <= 3'd1;
                  r_bus_idle  <= 1'b0;
                  r_state     <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               r_bus_idle <= 1'b0;
               if (w_res_vld) begin
                  if (!bus.stuffEnable) begin
                     r_bit_out   <= w_res_bit;
                     r_bit_valid <= 1'b1;
                     r_run_cnt   <= 3'd0;
                  end else if (r_run_cnt < RUN_MAX) begin
                     r_bit_out   <= w_res_bit;
                     r_bit_valid <= 1'b1;
                     if (w_res_bit == r_run_pol) begin
                        r_run_cnt <= r_run_cnt + 3'd1;
                     end else begin
                        r_run_pol <= w_res_bit;
                        r_run_cnt <= 3'd1;
                     end
                  end else if (w_res_bit != r_run_pol) begin
                     r_stuff_drop <= 1'b1;
                     r_run_pol    <= w_res_bit;
                     r_run_cnt    <= 3'd1;
                  end else begin
                     r_stuff_err <= 1'b1;
                     r_idle_cnt  <= 4'd0;
                     r_state     <= S_ERROR;
                  end
               end
               // Frame end wins over any transition taken by the bit above.
               if (bus.frameEnd) begin
                  r_run_cnt  <= 3'd0;
                  r_idle_cnt <= 4'd0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.bitOut     = r_bit_out;
   assign bus.bitValid   = r_bit_valid;
   assign bus.stuffDrop  = r_stuff_drop;
   assign bus.stuffErr   = r_stuff_err;
   assign bus.busIdle    = r_bus_idle;
   assign bus.sampleMiss = r_sample_miss;

`ifdef DESTUFF_STATS_EN
   logic [15:0] r_stuff_count;
   logic [15:0] r_err_count;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_stuff_count <= 16'd0;
         r_err_count   <= 16'd0;
      end else begin
         if (r_stuff_drop && (r_stuff_count != 16'hFFFF)) begin
            r_stuff_count <= r_stuff_count + 16'd1;
         end
         if (r_stuff_err && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
         end
      end
   end

   assign bus.stuffCount = r_stuff_count;
   assign bus.errCount   = r_err_count;
`else
   assign bus.stuffCount = 16'd0;
   assign bus.errCount   = 16'd0;
`endif

endmodule

// File: tb/tb_can_bit_destuffer.sv
module tb_can_bit_destuffer;
   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   can_bit_destuffer_if bus ();

   can_bit_destuffer #(.IDLE_BITS(11), .STUFF_LEN(5)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

`ifdef DESTUFF_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   int   obs_vcnt;
   logic obs_out, obs_drop, obs_err, obs_miss, obs_idle, obs_idle_post;

   task automatic clear_obs();
      obs_vcnt = 0;
      obs_drop = 1'b0;
      obs_err  = 1'b0;
      obs_miss = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.bitValid === 1'b1) obs_vcnt++;
      if (bus.stuffDrop === 1'b1) obs_drop = 1'b1;
      if (bus.stuffErr === 1'b1) obs_err = 1'b1;
      if (bus.sampleMiss === 1'b1) obs_miss = 1'b1;
      obs_out  = bus.bitOut;
      obs_idle = bus.busIdle;
   endtask

   // One bit period: bit-start edge, then nstr strobes with samples s[0..].
   task automatic send_bit(input logic multi, input int nstr, input logic [2:0] s,
                           input logic fe);
      tick();
      bus.syncCANClk  = 1'b1;
      bus.multiSelect = multi;
      tick();
      bus.syncCANClk = 1'b0;
      for (int i = 0; i < nstr; i++) begin
         tick();
         bus.syncIn        = s[i];
         bus.oneShotSample = 1'b1;
         bus.frameEnd      = fe && (i == nstr - 1);
         tick();
         obs_idle_post     = bus.busIdle;
         bus.oneShotSample = 1'b0;
         bus.frameEnd      = 1'b0;
      end
      tick();
   endtask

   task automatic send_idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1, 3'b111, 1'b0);
   endtask

   task automatic pulse_frame_end();
      tick();
      bus.frameEnd = 1'b1;
      tick();
      bus.frameEnd = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      clear_obs();
      tick();
      n_vec++;
      if ({bus.bitOut, bus.bitValid, bus.stuffDrop, bus.stuffErr, bus.busIdle, bus.sampleMiss} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 100000",
                  {bus.bitOut, bus.bitValid, bus.stuffDrop, bus.stuffErr, bus.busIdle, bus.sampleMiss});
      end
      n_vec++;
      if (bus.stuffCount !== 16'd0 || bus.errCount !== 16'd0) begin
         n_err++;
         $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.stuffCount, bus.errCount);
      end
   endtask

   task automatic test_idle();
      clear_obs();
      send_idle(10);
      n_vec++;
      if (obs_idle !== 1'b0 || obs_vcnt != 0) begin
         n_err++;
         $display("FAIL idle_10: got busIdle=%b valid=%0d want 0/0", obs_idle, obs_vcnt);
      end
      send_idle(1);
      n_vec++;
      if (obs_idle_post !== 1'b1 || obs_vcnt != 0) begin
         n_err++;
         $display("FAIL idle_11: got busIdle=%b valid=%0d want 1/0", obs_idle_post, obs_vcnt);
      end
   endtask

   task automatic test_stuff_drop();
      logic [6:0] bits  = 7'b0100000;   // bit i = i-th bit sent
      logic [6:0] evld  = 7'b1011111;
      logic [6:0] edrop = 7'b0100000;
      bus.stuffEnable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         clear_obs();
         send_bit(1'b0, 1, {2'b00, bits[i]}, 1'b0);
         n_vec++;
         if (obs_vcnt != int'(evld[i]) || obs_drop !== edrop[i] || obs_out !== 1'b0 || obs_err !== 1'b0) begin
            n_err++;
            $display("FAIL drop_bit%0d: got valid=%0d drop=%b out=%b err=%b want %0d/%b/0/0",
                     i, obs_vcnt, obs_drop, obs_out, obs_err, evld[i], edrop[i]);
         end
      end
      n_vec++;
      if (bus.stuffCount !== 16'(STATS)) begin
         n_err++;
         $display("FAIL drop_count: got %0d want %0d", bus.stuffCount, STATS);
      end
      pulse_frame_end();
   endtask

   task automatic test_stuff_err();
      clear_obs();
      send_idle(11);
      n_vec++;
      if (obs_idle !== 1'b1) begin
         n_err++;
         $display("FAIL err_pre_idle: got busIdle=%b want 1", obs_idle);
      end
      for (int i = 0; i < 6; i++) begin
         clear_obs();
         send_bit(1'b0, 1, 3'b000, 1'b0);
         n_vec++;
         if (obs_vcnt != ((i < 5) ? 1 : 0) || obs_err !== (i == 5) || obs_drop !== 1'b0) begin
            n_err++;
            $display("FAIL err_bit%0d: got valid=%0d err=%b drop=%b want %0d/%b/0",
                     i, obs_vcnt, obs_err, obs_drop, (i < 5) ? 1 : 0, (i == 5));
         end
      end
      clear_obs();
      send_idle(10);
      n_vec++;
      if (obs_idle !== 1'b0 || obs_err !== 1'b0 || obs_vcnt != 0) begin
         n_err++;
         $display("FAIL err_recover10: got busIdle=%b err=%b valid=%0d want 0/0/0", obs_idle, obs_err, obs_vcnt);
      end
      send_idle(1);
      n_vec++;
      if (obs_idle !== 1'b1) begin
         n_err++;
         $display("FAIL err_recover11: got busIdle=%b want 1", obs_idle);
      end
      n_vec++;
      if (bus.errCount !== 16'(STATS) || bus.stuffCount !== 16'(STATS)) begin
         n_err++;
         $display("FAIL err_count: got err=%0d stuff=%0d want %0d/%0d", bus.errCount, bus.stuffCount, STATS, STATS);
      end
   endtask

   task automatic test_multi();
      clear_obs();
      send_bit(1'b0, 1, 3'b000, 1'b0);   // SOF
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b0 || obs_idle !== 1'b0) begin
         n_err++;
         $display("FAIL multi_sof: got valid=%0d out=%b idle=%b want 1/0/0", obs_vcnt, obs_out, obs_idle);
      end
      clear_obs();
      send_bit(1'b1, 3, 3'b101, 1'b0);   // samples 1,0,1
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b1) begin
         n_err++;
         $display("FAIL multi_101: got valid=%0d out=%b want 1/1", obs_vcnt, obs_out);
      end
      clear_obs();
      send_bit(1'b1, 2, 3'b010, 1'b0);   // samples 0,1 then a new bit start
      tick();
      bus.syncCANClk = 1'b1;
      tick();
      bus.syncCANClk = 1'b0;
      tick();
      n_vec++;
      if (obs_miss !== 1'b1 || obs_vcnt != 0) begin
         n_err++;
         $display("FAIL multi_miss: got miss=%b valid=%0d want 1/0", obs_miss, obs_vcnt);
      end
      clear_obs();
      send_bit(1'b1, 3, 3'b100, 1'b0);   // samples 0,0,1
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b0 || obs_miss !== 1'b0) begin
         n_err++;
         $display("FAIL multi_001: got valid=%0d out=%b miss=%b want 1/0/0", obs_vcnt, obs_out, obs_miss);
      end
      clear_obs();
      send_bit(1'b0, 2, 3'b001, 1'b0);   // single mode: 1 then ignored 0
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b1) begin
         n_err++;
         $display("FAIL single_extra: got valid=%0d out=%b want 1/1", obs_vcnt, obs_out);
      end
   endtask

   task automatic test_frame_end_bit();
      clear_obs();
      send_bit(1'b0, 1, 3'b001, 1'b1);
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b1 || obs_idle !== 1'b0) begin
         n_err++;
         $display("FAIL fe_bit: got valid=%0d out=%b idle=%b want 1/1/0", obs_vcnt, obs_out, obs_idle);
      end
      clear_obs();
      send_bit(1'b0, 1, 3'b000, 1'b0);
      n_vec++;
      if (obs_vcnt != 0 || obs_out !== 1'b1) begin
         n_err++;
         $display("FAIL fe_after: got valid=%0d out=%b want 0/1", obs_vcnt, obs_out);
      end
   endtask

   task automatic test_reset_midframe();
      send_idle(11);
      clear_obs();
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1, 3'b000, 1'b0);
      n_vec++;
      if (obs_vcnt != 3 || bus.bitOut !== 1'b0) begin
         n_err++;
         $display("FAIL mid_pre: got valid=%0d out=%b want 3/0", obs_vcnt, bus.bitOut);
      end
      @(negedge clk);
      #2 resetN = 1'b0;
      #1;
      n_vec++;
      if ({bus.bitOut, bus.bitValid, bus.stuffDrop, bus.stuffErr, bus.busIdle, bus.sampleMiss} !== 6'b100000
          || bus.stuffCount !== 16'd0 || bus.errCount !== 16'd0) begin
         n_err++;
         $display("FAIL mid_async: got flags=%b counts=%0d/%0d want 100000 0/0",
                  {bus.bitOut, bus.bitValid, bus.stuffDrop, bus.stuffErr, bus.busIdle, bus.sampleMiss},
                  bus.stuffCount, bus.errCount);
      end
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      clear_obs();
      send_bit(1'b0, 1, 3'b000, 1'b0);
      send_idle(5);
      send_bit(1'b0, 1, 3'b000, 1'b0);
      n_vec++;
      if (obs_vcnt != 0 || obs_idle !== 1'b0) begin
         n_err++;
         $display("FAIL mid_no_sof: got valid=%0d idle=%b want 0/0", obs_vcnt, obs_idle);
      end
      send_idle(11);
      clear_obs();
      send_bit(1'b0, 1, 3'b000, 1'b0);
      n_vec++;
      if (obs_vcnt != 1 || obs_out !== 1'b0) begin
         n_err++;
         $display("FAIL mid_sof: got valid=%0d out=%b want 1/0", obs_vcnt, obs_out);
      end
      pulse_frame_end();
   endtask

   initial begin
      bus.syncIn        = 1'b1;
      bus.oneShotSample = 1'b0;
      bus.syncCANClk    = 1'b0;
      bus.multiSelect   = 1'b0;
      bus.stuffEnable   = 1'b0;
      bus.frameEnd      = 1'b0;
      obs_idle_post     = 1'b0;
      clear_obs();
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      test_reset();
      test_idle();
      test_stuff_drop();
      test_stuff_err();
      test_multi();
      test_frame_end_bit();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
